auc_au_arb: RTL and testbench
=============================

// Module: auc_au_arb
// PURPOSE
//  Shares one arithmetic unit (AU: FA/MUL/INV) and its operand RAM ports between NREQ sequencers
//  (affine conversion, point add, point double, scalar-mult control).
//  A requester owns the AU from grant until it signals done. The arbiter forwards the owner's
//  start/opcode/RAM controls and routes AU results back to the owner only.
//  Grant order is round-robin. Ownership is released only once no AU operation is outstanding.
// PARAMETERS
//  WIDTH     256   AU data / RAM word width
//  ADDR      5     RAM address width
//  NREQ      4     number of requesters (2..8)
//  WDOG_CYC  1023  watchdog limit in cycles (used only with AUC_ARB_WDOG_EN)
// PORTS
//  clk         in   1           clock
//  rst         in   1           reset, asynchronous, active-low
//  req_en      in   NREQ        per-requester ownership request, level; held until done
//  req_start   in   NREQ        per-requester AU start pulse
//  req_opcode  in   NREQ*4      per-requester opcode, slice i = [4i+3:4i]
//  req_radd    in   NREQ*ADDR   per-requester RAM read address
//  req_wen     in   NREQ        per-requester RAM write enable
//  req_wadd    in   NREQ*ADDR   per-requester RAM write address
//  req_wdat    in   NREQ*WIDTH  per-requester RAM write data
//  req_done    in   NREQ        per-requester release pulse
//  gnt         out  NREQ        one-hot grant, registered
//  gnt_auvld   out  NREQ        AU result valid, routed to the owner only
//  gnt_audat   out  WIDTH       AU result data, broadcast to all requesters
//  au_start    out  1           forwarded to the AU
//  au_opcode   out  4           forwarded to the AU
//  au_vld      in   1           AU result valid
//  au_dat      in   WIDTH       AU result data
//  ram_radd    out  ADDR        RAM read address
//  ram_wen     out  1           RAM write enable
//  ram_wadd    out  ADDR        RAM write address
//  ram_wdat    out  WIDTH       RAM write data
//  arb_busy    out  1           1 in GRANT or DRAIN
//  arb_err     out  1           watchdog expiry pulse
// BEHAVIOUR
//  Reset (rst=0):
//   - all outputs 0; state IDLE; rr_ptr=0; owner=0; outstanding=0.
//  FSM IDLE -> GRANT -> DRAIN -> IDLE:
//   - IDLE: if any req_en, pick the first set bit at or after rr_ptr (wrapping), register it as
//     owner, set gnt next cycle. One cycle from req_en to gnt.
//   - GRANT: au_start, au_opcode, ram_* are a combinational mux of the owner's inputs (0 added
//     latency); all are 0 whenever gnt=0. gnt_auvld[owner]=au_vld; other bits are 0.
//     On req_done[owner], or req_en[owner] falling (abort), go to DRAIN. An owner write in the
//     same cycle as done is still forwarded.
//   - DRAIN: forwarding off, gnt held. Stay while outstanding!=0. Then go to IDLE: gnt=0,
//     rr_ptr=owner+1 mod NREQ.
//  outstanding: 3-bit counter, +1 on forwarded au_start, -1 on au_vld; both in one cycle = no
//   change. Saturates at 7; underflow is blocked.
//  Boundaries:
//   - au_vld while outstanding=0, or while in IDLE: dropped; gnt_auvld stays 0.
//   - req_done without req_en: ignored.
//   - Inputs from requesters that are not the owner: ignored.
//   - Start and done in the same cycle: start forwarded, DRAIN waits for its result.
//   - Asynchronous reset mid-operation: immediate return to the reset state; an AU result still
//     in flight afterwards is dropped.
//  gnt_audat = au_dat, unconditioned.
// CONFIGURATION
//  AUC_ARB_WDOG_EN defined:
//   - Counter clears on any forwarded start/wen or au_vld; it counts in GRANT and DRAIN.
//   - When it reaches WDOG_CYC: one-cycle arb_err pulse, outstanding cleared, forced to IDLE
//     with rr_ptr advanced.
//  AUC_ARB_WDOG_EN undefined:
//   - No counter; arb_err tied 0.
// STRUCTURE
//  auc_pkg:
//   - OP_FA/OP_MUL/OP_INV opcodes, RAM slot localparams (X_KG, TEMP0..8, ...).
//   - Arbiter state encoding, default NREQ.
//  Sub-module auc_rr_pick: combinational round-robin picker (req, ptr -> one-hot, index, any).
// TESTING
//  1. Reset, req_en=0001 -> gnt=0001 next cycle; OP_MUL start forwarded same cycle;
//     au_vld -> gnt_auvld=0001.
//  2. req_en=1111 with each owner finishing in turn -> grant order 0,1,2,3,0; one IDLE cycle
//     between owners.
//  3. Owner pulses req_done while 1 op is outstanding -> gnt held in DRAIN until au_vld,
//     then released.
//  4. Non-owner req_start/req_wen asserted -> au_start and ram_wen stay 0.
//  5. Reset deasserted-to-asserted in GRANT with outstanding=2 -> all outputs 0 at once;
//     the later au_vld is dropped.
//  6. (WDOG_EN, WDOG_CYC=15) owner goes idle for 15 cycles -> arb_err pulses once, gnt=0,
//     next requester granted.

Source files
------------

// File: rtl/auc_pkg.sv
// rtl/auc_pkg.sv - shared opcodes, RAM slot map and arbiter encodings for the AU complex
package auc_pkg;

    localparam int AUC_NREQ = 4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_FA  = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_INV = 4'h3;

    localparam logic [4:0] X_KG  = 5'd0;
    localparam logic [4:0] Y_KG  = 5'd1;
    localparam logic [4:0] Z_KG  = 5'd2;
    localparam logic [4:0] X_P   = 5'd3;
    localparam logic [4:0] Y_P   = 5'd4;
    localparam logic [4:0] CURVE_A = 5'd5;
    localparam logic [4:0] TEMP0 = 5'd8;
    localparam logic [4:0] TEMP1 = 5'd9;
    localparam logic [4:0] TEMP2 = 5'd10;
    localparam logic [4:0] TEMP3 = 5'd11;
    localparam logic [4:0] TEMP4 = 5'd12;
    localparam logic [4:0] TEMP5 = 5'd13;
    localparam logic [4:0] TEMP6 = 5'd14;
    localparam logic [4:0] TEMP7 = 5'd15;
    localparam logic [4:0] TEMP8 = 5'd16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/auc_rr_pick.sv
// rtl/auc_rr_pick.sv - combinational round-robin picker: first request at or after ptr, wrapping
module auc_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // Scan from the far end back toward ptr so the nearest request overwrites the rest.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                onehot = '0;
                onehot[(int'(ptr) + k) % NREQ] = 1'b1;
                idx = IW'((int'(ptr) + k) % NREQ);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/auc_au_arb.sv
// rtl/auc_au_arb.sv - round-robin owner arbiter for the shared AU and operand RAM ports
// Optional watchdog enabled by defining AUC_ARB_WDOG_EN.
module auc_au_arb
    import auc_pkg::*;
#(
    parameter int WIDTH    = 256,
    parameter int ADDR     = 5,
    parameter int NREQ     = AUC_NREQ,
    parameter int WDOG_CYC = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_en,
    input  logic [NREQ-1:0]      req_start,
    input  logic [NREQ*4-1:0]    req_opcode,
    input  logic [NREQ*ADDR-1:0] req_radd,
    input  logic [NREQ-1:0]      req_wen,
    input  logic [NREQ*ADDR-1:0] req_wadd,
    input  logic [NREQ*WIDTH-1:0] req_wdat,
    input  logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      gnt_auvld,
    output logic [WIDTH-1:0]     gnt_audat,
    output logic                 au_start,
    output logic [3:0]           au_opcode,
    input  logic                 au_vld,
    input  logic [WIDTH-1:0]     au_dat,
    output logic [ADDR-1:0]      ram_radd,
    output logic                 ram_wen,
    output logic [ADDR-1:0]      ram_wadd,
    output logic [WIDTH-1:0]     ram_wdat,
    output logic                 arb_busy,
    output logic                 arb_err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic [NREQ-1:0] gnt_q;
    logic            pick_any;
    logic [2:0]      outstanding;
    logic            fwd;
    logic            own_en;
    logic            own_done;
    logic            vld_ok;
    logic            release_own;
    logic            wdog_hit;

    auc_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req    (req_en),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign own_en      = req_en[owner];
    assign own_done    = req_done[owner] & own_en;
    assign fwd         = (state == ARB_GRANT);
    // A result is only meaningful if something was started by the current owner.
    assign vld_ok      = au_vld && (outstanding != 3'd0) && (state != ARB_IDLE);
    assign release_own = wdog_hit || ((state == ARB_DRAIN) && (outstanding == 3'd0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE:  if (pick_any) state_nxt = ARB_GRANT;
            ARB_GRANT: if (own_done || !own_en) state_nxt = ARB_DRAIN;
            ARB_DRAIN: if (outstanding == 3'd0) state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
        if (wdog_hit) state_nxt = ARB_IDLE;
    end

    always_comb begin
        au_start  = 1'b0;
        au_opcode = '0;
        ram_radd  = '0;
        ram_wen   = 1'b0;
        ram_wadd  = '0;
        ram_wdat  = '0;
        if (fwd) begin
            au_start  = req_start[owner];
            au_opcode = req_opcode[int'(owner)*4 +: 4];
            ram_radd  = req_radd[int'(owner)*ADDR +: ADDR];
            ram_wen   = req_wen[owner];
            ram_wadd  = req_wadd[int'(owner)*ADDR +: ADDR];
            ram_wdat  = req_wdat[int'(owner)*WIDTH +: WIDTH];
        end
        gnt_auvld = vld_ok ? gnt_q : '0;
        arb_busy  = (state != ARB_IDLE);
    end

    assign gnt       = gnt_q;
    assign gnt_audat = au_dat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner  <= '0;
            rr_ptr <= '0;
            gnt_q  <= '0;
        end else if (release_own) begin
            gnt_q  <= '0;
            rr_ptr <= IW'(rr_next(int'(owner), NREQ));
        end else if ((state == ARB_IDLE) && pick_any) begin
            owner <= pick_idx;
            gnt_q <= pick_oh;
        end
    end

    // Start and result in the same cycle cancel; the counter never wraps either way.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= 3'd0;
        end else if (wdog_hit) begin
            outstanding <= 3'd0;
        end else if (au_start && !vld_ok && (outstanding != 3'd7)) begin
            outstanding <= outstanding + 3'd1;
        end else if (vld_ok && !au_start) begin
            outstanding <= outstanding - 3'd1;
        end
    end

`ifdef AUC_ARB_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);

    logic [WW-1:0] wdog_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt <= '0;
        end else if ((state == ARB_IDLE) || wdog_hit || au_start || ram_wen || au_vld) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign wdog_hit = (state != ARB_IDLE) && (wdog_cnt == WW'(WDOG_CYC));
    assign arb_err  = wdog_hit;
`else
    assign wdog_hit = (WDOG_CYC < 0);
    assign arb_err  = 1'b0;
`endif

endmodule

// File: tb/tb_auc_au_arb.sv
// tb/tb_auc_au_arb.sv - directed bench with a per-cycle ownership model for auc_au_arb
module tb_auc_au_arb;
    import auc_pkg::*;

    localparam int W  = 16;
    localparam int A  = 5;
    localparam int N  = 4;
    localparam int WD = 15;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_en = '0, req_start = '0, req_wen = '0, req_done = '0;
    logic [N*4-1:0] req_opcode = '0;
    logic [N*A-1:0] req_radd = '0, req_wadd = '0;
    logic [N*W-1:0] req_wdat = '0;
    logic           au_vld = 1'b0;
    logic [W-1:0]   au_dat = '0;
    logic [N-1:0]   gnt, gnt_auvld;
    logic [W-1:0]   gnt_audat, ram_wdat;
    logic           au_start, ram_wen, arb_busy, arb_err;
    logic [3:0]     au_opcode;
    logic [A-1:0]   ram_radd, ram_wadd;

    always #5 clk = ~clk;

    auc_au_arb #(.WIDTH(W), .ADDR(A), .NREQ(N), .WDOG_CYC(WD)) dut (
        .clk(clk), .rst(rst), .req_en(req_en), .req_start(req_start), .req_opcode(req_opcode),
        .req_radd(req_radd), .req_wen(req_wen), .req_wadd(req_wadd), .req_wdat(req_wdat),
        .req_done(req_done), .gnt(gnt), .gnt_auvld(gnt_auvld), .gnt_audat(gnt_audat),
        .au_start(au_start), .au_opcode(au_opcode), .au_vld(au_vld), .au_dat(au_dat),
        .ram_radd(ram_radd), .ram_wen(ram_wen), .ram_wadd(ram_wadd), .ram_wdat(ram_wdat),
        .arb_busy(arb_busy), .arb_err(arb_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ownership model: who owns the AU, whether it is finishing, and how many results it awaits.
    int m_owner = -1;
    bit m_drain = 1'b0;
    int m_pend  = 0;
    int m_ptr   = 0;
    int m_quiet = 0;

    function automatic bit m_err();
`ifdef AUC_ARB_WDOG_EN
        return (m_owner >= 0) && (m_quiet == WD);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst) begin
        int o;
        bit fw, st, vl, act, err;
        int pend0;
        if (!rst) begin
            m_owner = -1; m_drain = 0; m_pend = 0; m_ptr = 0; m_quiet = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && req_en[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            end
            m_quiet = 0;
        end else begin
            o   = m_owner;
            fw  = !m_drain;
            st  = fw && req_start[o];
            vl  = au_vld && (m_pend > 0);
            act = st || (fw && req_wen[o]) || au_vld;
            err = m_err();
            pend0 = m_pend;
            if (err) begin
                m_owner = -1; m_ptr = (o + 1) % N; m_pend = 0; m_drain = 0; m_quiet = 0;
            end else begin
                if (st && !vl && m_pend < 7) m_pend++;
                else if (vl && !st) m_pend--;
                m_quiet = act ? 0 : m_quiet + 1;
                if (!m_drain) begin
                    if (!req_en[o] || req_done[o]) m_drain = 1;
                end else if (pend0 == 0) begin
                    m_owner = -1; m_ptr = (o + 1) % N; m_drain = 0; m_quiet = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg;
        bit fw;
        int oo;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        fw = (m_owner >= 0) && !m_drain;
        oo = (m_owner < 0) ? 0 : m_owner;
        chk("m_gnt", gnt, eg);
        chk("m_au_start", au_start, fw ? req_start[oo] : 1'b0);
        chk("m_au_opcode", au_opcode, fw ? req_opcode[oo*4 +: 4] : 4'd0);
        chk("m_ram_radd", ram_radd, fw ? req_radd[oo*A +: A] : '0);
        chk("m_ram_wen", ram_wen, fw ? req_wen[oo] : 1'b0);
        chk("m_ram_wadd", ram_wadd, fw ? req_wadd[oo*A +: A] : '0);
        chk("m_ram_wdat", ram_wdat, fw ? req_wdat[oo*W +: W] : '0);
        chk("m_gnt_auvld", gnt_auvld, (m_owner >= 0 && au_vld && m_pend > 0) ? eg : '0);
        chk("m_gnt_audat", gnt_audat, au_dat);
        chk("m_arb_busy", arb_busy, m_owner >= 0);
        chk("m_arb_err", arb_err, m_err());
    end

    logic [N-1:0] exp2 [5];

    initial begin
        int errs;
        bit saw_zero;
        for (int i = 0; i < N; i++) begin
            req_opcode[i*4 +: 4] = 4'(i + 4);
            req_radd[i*A +: A]   = A'(3*i + 1);
            req_wadd[i*A +: A]   = A'(5*i + 2);
            req_wdat[i*W +: W]   = W'(16'hA000 + i);
        end
        repeat (3) tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", arb_busy, 0);
        chk("rst_start", au_start, 0);
        chk("rst_auvld", gnt_auvld, 0);
        rst = 1'b1;
        tick();

        // single owner: grant latency, forwarding, result routing
        req_en = 4'b0001;
        tick();
        chk("t1_gnt", gnt, 4'b0001);
        req_start[0] = 1'b1; req_opcode[3:0] = OP_MUL;
        #1;
        chk("t1_start", au_start, 1);
        chk("t1_opcode", au_opcode, OP_MUL);
        tick();
        req_start = '0; au_vld = 1'b1; au_dat = 16'h1234;
        #1;
        chk("t1_auvld", gnt_auvld, 4'b0001);
        chk("t1_audat", gnt_audat, 16'h1234);
        tick();
        au_vld = 1'b0; req_done[0] = 1'b1;
        tick();
        req_done = '0; req_en = '0;
        tick();
        chk("t1_release", gnt, 0);

        // round-robin order with all requesting
        rst = 1'b0; tick(); rst = 1'b1; tick();
        exp2[0] = 4'b0001; exp2[1] = 4'b0010; exp2[2] = 4'b0100; exp2[3] = 4'b1000; exp2[4] = 4'b0001;
        req_en = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            chk($sformatf("t2_gnt%0d", g), gnt, exp2[g]);
            if (g < 4) begin
                req_done = gnt;
                tick();
                req_done = '0;
                chk($sformatf("t2_drain%0d", g), gnt, exp2[g]);
                tick();
                chk($sformatf("t2_gap%0d", g), gnt, 0);
                tick();
            end
        end
        req_en = '0;
        repeat (3) tick();

        // boundaries in IDLE, then done with a start in flight
        au_vld = 1'b1; req_done = 4'b0001;
        #1;
        chk("t3_idle_vld", gnt_auvld, 0);
        tick();
        au_vld = 1'b0; req_done = '0;
        chk("t3_done_noen", arb_busy, 0);
        req_en = 4'b0100;
        tick();
        chk("t3_gnt", gnt, 4'b0100);
        au_vld = 1'b1;
        #1;
        chk("t3_vld_nopend", gnt_auvld, 0);
        tick();
        au_vld = 1'b0;
        req_start[2] = 1'b1; req_done[2] = 1'b1; req_opcode[11:8] = OP_FA;
        #1;
        chk("t3_start", au_start, 1);
        chk("t3_opcode", au_opcode, OP_FA);
        tick();
        req_done = '0; req_en = '0;
        #1;
        chk("t3_drain_nofwd", au_start, 0);
        req_start = '0;
        repeat (3) begin
            tick();
            chk("t3_hold", gnt, 4'b0100);
        end
        au_vld = 1'b1;
        #1;
        chk("t3_drain_vld", gnt_auvld, 4'b0100);
        tick();
        au_vld = 1'b0;
        chk("t3_still", gnt, 4'b0100);
        tick();
        chk("t3_released", gnt, 0);

        // non-owner inputs ignored; owner write with done still forwarded
        req_en = 4'b1000;
        tick();
        chk("t4_gnt", gnt, 4'b1000);
        req_start = 4'b0111; req_wen = 4'b0111; req_done = 4'b0111;
        #1;
        chk("t4_start", au_start, 0);
        chk("t4_wen", ram_wen, 0);
        chk("t4_radd", ram_radd, 5'd10);
        chk("t4_wadd", ram_wadd, 5'd17);
        tick();
        chk("t4_keep", gnt, 4'b1000);
        req_start = '0; req_wen = 4'b1000; req_done = 4'b1000;
        #1;
        chk("t4_own_wen", ram_wen, 1);
        chk("t4_own_wdat", ram_wdat, 16'hA003);
        tick();
        req_wen = '0; req_done = '0; req_en = '0;
        tick();
        chk("t4_released", gnt, 0);

        // async reset with two results outstanding
        req_en = 4'b0010;
        tick();
        chk("t5_gnt", gnt, 4'b0010);
        req_start[1] = 1'b1;
        tick();
        tick();
        rst = 1'b0; au_vld = 1'b1;
        #1;
        chk("t5_gnt0", gnt, 0);
        chk("t5_busy0", arb_busy, 0);
        chk("t5_start0", au_start, 0);
        chk("t5_auvld0", gnt_auvld, 0);
        tick();
        rst = 1'b1; req_en = '0; req_start = '0;
        #1;
        chk("t5_late_vld", gnt_auvld, 0);
        tick();
        au_vld = 1'b0;
        req_en = 4'b0001;
        tick();
        chk("t5_regrant", gnt, 4'b0001);
        au_vld = 1'b1;
        #1;
        chk("t5_pend_cleared", gnt_auvld, 0);
        tick();
        au_vld = 1'b0; req_en = '0;
        repeat (3) tick();

`ifdef AUC_ARB_WDOG_EN
        rst = 1'b0; tick(); rst = 1'b1; tick();
        req_en = 4'b0011;
        tick();
        chk("t6_gnt", gnt, 4'b0001);
        errs = 0; saw_zero = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (arb_err) errs++;
            if (gnt == 4'b0000) saw_zero = 1'b1;
            if (gnt == 4'b0010) break;
            tick();
        end
        chk("t6_err_once", errs, 1);
        chk("t6_gap", saw_zero, 1);
        chk("t6_next", gnt, 4'b0010);
        req_en = '0;
        repeat (3) tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
